// File: rtl/riu_pkg.sv
// Shared definitions for the RV32 EX-stage units: ALU opcode constants that
// the control unit also drives, and the multiply sequencer state type.
package riu_pkg;

  localparam logic [3:0] ALUOP_MUL   = 4'b0101;
  localparam logic [3:0] ALUOP_MULH  = 4'b0110;
  localparam logic [3:0] ALUOP_MULHU = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mulseq_state_t;

  // True for the three opcodes the multiply sequencer executes.
  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == ALUOP_MUL) || (op == ALUOP_MULH) || (op == ALUOP_MULHU);
  endfunction

endpackage

// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHU.
// Operands are converted to magnitudes on accept, multiplied unsigned over
// WIDTH RUN cycles, and the sign is reapplied to the full 2*WIDTH product in
// FIX. The pipeline is held via stall_EX until the DONE cycle.
//
// Handshake: start/aluop_EX is a request that is only consumed in IDLE
// (cycle 0); stall_EX tells the pipeline the request has not completed yet.
// done is a one-cycle pulse in which result is valid and stall_EX is low, so
// the consumer captures result at the end of that same cycle. There is no
// backpressure on done.
//
// The FSM state is available on the internal signal `state` (mulseq_state_t)
// for hierarchical observation.
module mul_seq
  import riu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       aluop_EX,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall_EX,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  mulseq_state_t          state;
  logic [3:0]             op_q;
  logic                   neg;
  logic [WIDTH-1:0]       mcand;
  logic [2*WIDTH-1:0]     p;
  logic [CW-1:0]          count;

  logic                   accept;
  logic                   signed_op;
  logic [WIDTH-1:0]       abs_a;
  logic [WIDTH-1:0]       abs_b;
  logic [WIDTH:0]         sum;
  logic [2*WIDTH-1:0]     p_fix;

  // Operand conditioning, the single adder and the single negator.
  always_comb begin
    accept    = (state == IDLE) && start && is_mul_op(aluop_EX);
    // MUL is handled as signed; its low half is the same either way.
    signed_op = (aluop_EX != ALUOP_MULHU);
    // The most negative value maps to 2^(WIDTH-1), which fits unsigned.
    abs_a     = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    abs_b     = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
    sum       = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mcand} : '0);
    p_fix     = neg ? (~p + {{(2*WIDTH-1){1'b0}}, 1'b1}) : p;
  end

  // Stall covers the accept cycle plus every RUN and FIX cycle; reset forces it low.
  assign stall_EX = (accept && rst_n) || (state == RUN) || (state == FIX);

  // Sequencer FSM with datapath registers and registered done/result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= 4'b0;
      neg    <= 1'b0;
      mcand  <= '0;
      p      <= '0;
      count  <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            op_q  <= aluop_EX;
            neg   <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand <= abs_a;
            p     <= {{WIDTH{1'b0}}, abs_b};
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Add into the upper half, then shift {carry, P} right by one.
          p     <= {sum, p[WIDTH-1:1]};
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          p      <= p_fix;
          result <= (op_q == ALUOP_MUL) ? p_fix[WIDTH-1:0] : p_fix[2*WIDTH-1:WIDTH];
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: a product model built from 64-bit arithmetic plus a
// cycle-level timing model (accept cycle, stall window, done cycle), checked
// every falling edge against the DUT.
module tb_mul_seq;
  import riu_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   aluop_EX = 4'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         stall_EX;
  logic         done;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  mul_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .aluop_EX (aluop_EX),
    .a        (a),
    .b        (b),
    .stall_EX (stall_EX),
    .done     (done),
    .result   (result)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference product straight from 64-bit arithmetic.
  function automatic logic [W-1:0] model_mul(input logic [3:0] op, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    logic signed [2*W-1:0] sx, sy, sp;
    logic [2*W-1:0]        ux, uy, up;
    sx = {{W{x[W-1]}}, x};
    sy = {{W{y[W-1]}}, y};
    sp = sx * sy;
    ux = {{W{1'b0}}, x};
    uy = {{W{1'b0}}, y};
    up = ux * uy;
    case (op)
      ALUOP_MUL:  return sp[W-1:0];
      ALUOP_MULH: return sp[2*W-1:W];
      default:    return up[2*W-1:W];
    endcase
  endfunction

  // ---------------- scoreboard / timing model ----------------
  logic [W-1:0] exp_q[$];
  bit           acc_valid = 1'b0;
  int           acc_cyc   = 0;

  always @(negedge clk) begin
    bit           exp_done;
    bit           in_busy;
    bit           acc_now;
    logic [W-1:0] e;
    if (!rst_n) begin
      acc_valid = 1'b0;
      exp_q.delete();
      check_bit("rst_stall", stall_EX, 1'b0);
      check_bit("rst_done", done, 1'b0);
      check("rst_result", result, '0);
    end else begin
      exp_done = acc_valid && (cyc == acc_cyc + W + 2);
      in_busy  = acc_valid && (cyc > acc_cyc) && (cyc <= acc_cyc + W + 1);
      acc_now  = !(acc_valid && (cyc <= acc_cyc + W + 2)) && start && is_mul_op(aluop_EX);
      check_bit("stall", stall_EX, in_busy || acc_now);
      check_bit("done", done, exp_done);
      if (exp_done) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check("result", result, e);
        acc_valid = 1'b0;
      end
      if (acc_now) begin
        acc_valid = 1'b1;
        acc_cyc   = cyc;
        exp_q.push_back(model_mul(aluop_EX, a, b));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit s, input logic [3:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    @(posedge clk);
    #1;
    start    = s;
    aluop_EX = op;
    a        = x;
    b        = y;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'b0000, $urandom, $urandom);
  endtask

  // One request followed by exactly enough idle cycles for back-to-back issue.
  task automatic mul_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    drive(1'b1, op, x, y);
    idle(W + 2);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [3:0] pick_op();
    case ($urandom_range(0, 4))
      0:       return ALUOP_MUL;
      1:       return ALUOP_MULH;
      2:       return ALUOP_MULHU;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    // Hand-computed values that pin the reference model.
    check("pin_mul_7_6",    model_mul(ALUOP_MUL,   32'd7,        32'd6),        32'h0000_002A);
    check("pin_mulh_m1",    model_mul(ALUOP_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0000_0000);
    check("pin_mulhu_m1",   model_mul(ALUOP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("pin_mul_m1",     model_mul(ALUOP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0000_0001);
    check("pin_mulh_min",   model_mul(ALUOP_MULH,  32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("pin_mulhu_min",  model_mul(ALUOP_MULHU, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("pin_mul_min",    model_mul(ALUOP_MUL,   32'h8000_0000, 32'h8000_0000), 32'h0000_0000);
    check("pin_mulh_3_m2",  model_mul(ALUOP_MULH,  32'd3,        32'hFFFF_FFFE), 32'hFFFF_FFFF);
    check("pin_mul_3_m2",   model_mul(ALUOP_MUL,   32'd3,        32'hFFFF_FFFE), 32'hFFFF_FFFA);
    check("pin_mulhu_3_m2", model_mul(ALUOP_MULHU, 32'd3,        32'hFFFF_FFFE), 32'h0000_0002);

    // Power-on reset.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Directed vectors, issued back-to-back at the maximum rate.
    mul_op(ALUOP_MUL,   32'd7,        32'd6);
    mul_op(ALUOP_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mul_op(ALUOP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mul_op(ALUOP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mul_op(ALUOP_MULH,  32'h8000_0000, 32'h8000_0000);
    mul_op(ALUOP_MULHU, 32'h8000_0000, 32'h8000_0000);
    mul_op(ALUOP_MUL,   32'h8000_0000, 32'h8000_0000);
    mul_op(ALUOP_MULH,  32'd3,        32'hFFFF_FFFE);
    mul_op(ALUOP_MUL,   32'd3,        32'hFFFF_FFFE);
    mul_op(ALUOP_MULHU, 32'd3,        32'hFFFF_FFFE);

    // Non-mul opcode must not stall or complete.
    drive(1'b1, 4'b0011, 32'd4, 32'd5);
    idle(W + 4);

    // Extra starts and operand changes during RUN are ignored.
    drive(1'b1, ALUOP_MUL, 32'd2, 32'd3);
    drive(1'b1, ALUOP_MUL, 32'd9, 32'd9);
    drive(1'b1, ALUOP_MULH, 32'hDEAD_BEEF, 32'h1234_5678);
    idle(W + 1);

    // Asynchronous reset in cycle 10 of a MUL.
    drive(1'b1, ALUOP_MUL, 32'h0001_2345, 32'h0000_0777);
    idle(9);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("async_rst_stall", stall_EX, 1'b0);
    check_bit("async_rst_done", done, 1'b0);
    check("async_rst_result", result, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    mul_op(ALUOP_MUL, 32'd5, 32'd5);

    // Randomized traffic, including starts while busy and non-mul opcodes.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 3) == 0, pick_op(), pick_operand(), pick_operand());
    end

    // Let any in-flight operation finish, then confirm nothing is outstanding.
    idle(W + 5);
    check("drain", W'(exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
